// File: rtl/ex_stage_mdu_pkg.sv
// Shared encodings for the execute stage and its multiply/divide unit.
// MDU op codes are decoded upstream; FSM states are private to the MDU.
package ex_stage_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  localparam logic [4:0] EXC_OV = 5'd12;

  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/ex_stage_mdu_iter.sv
// Iterative multiply/divide unit: FSM, counter, restoring divider, multiplier, HI/LO.
// HI/LO commit on the edge the MDU instruction leaves the stage, or on an accepted MTHI/MTLO.
module ex_stage_mdu_iter
  import ex_stage_mdu_pkg::*;
#(
  parameter int W       = 32,
  parameter int MUL_LAT = 5
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_flush,
  input  logic         i_live,
  input  logic         i_allowin_next,
  input  logic [3:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_start,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  localparam int CNT_MAX = (W > MUL_LAT) ? W : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_DIV = CW'(W);
  localparam logic [CW-1:0] CNT_MUL = CW'(MUL_LAT);

  mdu_state_e      r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_a, r_b, r_rem, r_quo, r_dvs, r_hi, r_lo;
  logic            r_sgn, r_div, r_qneg, r_rneg;

  logic            w_go, w_sgn, w_accept;
  logic [W-1:0]    w_abs_a, w_abs_b, w_q_fix, w_r_fix, w_hi_res, w_lo_res;
  logic [W:0]      w_shift, w_trial;
  logic [2*W-1:0]  w_ax, w_bx, w_prod;

  assign w_sgn   = is_signed_op(i_op);
  assign w_go    = i_live && is_mdu_op(i_op) && (r_state == ST_IDLE);
  assign w_abs_a = (w_sgn && i_a[W-1]) ? -i_a : i_a;
  assign w_abs_b = (w_sgn && i_b[W-1]) ? -i_b : i_b;

  always_comb begin
    w_state_nxt = r_state;
    o_start     = 1'b0;
    case (r_state)
      ST_IDLE: if (w_go) begin
        w_state_nxt = ST_BUSY;
        o_start     = 1'b1;
      end
      ST_BUSY: if (r_cnt == CW'(1)) w_state_nxt = ST_DONE;
      ST_DONE: if (i_allowin_next) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (i_flush) w_state_nxt = ST_IDLE;
  end

  // One restoring step: remainder never exceeds W bits, bit W flags a failed trial.
  assign w_shift  = {r_rem, r_quo[W-1]};
  assign w_trial  = w_shift - {1'b0, r_dvs};
  assign w_accept = !w_trial[W];

  assign w_ax   = {{W{r_sgn & r_a[W-1]}}, r_a};
  assign w_bx   = {{W{r_sgn & r_b[W-1]}}, r_b};
  assign w_prod = w_ax * w_bx;

  assign w_q_fix  = r_qneg ? -r_quo : r_quo;
  assign w_r_fix  = r_rneg ? -r_rem : r_rem;
  assign w_hi_res = r_div ? w_r_fix : w_prod[2*W-1:W];
  assign w_lo_res = r_div ? w_q_fix : w_prod[W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_sgn   <= 1'b0;
      r_div   <= 1'b0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_go) begin
        r_cnt  <= is_div_op(i_op) ? CNT_DIV : CNT_MUL;
        r_a    <= i_a;
        r_b    <= i_b;
        r_rem  <= '0;
        r_quo  <= w_abs_a;
        r_dvs  <= w_abs_b;
        r_sgn  <= w_sgn;
        r_div  <= is_div_op(i_op);
        r_qneg <= w_sgn && (i_a[W-1] ^ i_b[W-1]);
        r_rneg <= w_sgn && i_a[W-1];
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_div) begin
          r_rem <= w_accept ? w_trial[W-1:0] : w_shift[W-1:0];
          r_quo <= {r_quo[W-2:0], w_accept};
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == ST_DONE && i_allowin_next && !i_flush) begin
      r_hi <= w_hi_res;
      r_lo <= w_lo_res;
    end else if (i_live && i_allowin_next) begin
      if (i_op == MDU_MTHI) r_hi <= i_a;
      if (i_op == MDU_MTLO) r_lo <= i_a;
    end
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_done = (r_state == ST_DONE);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage with iterative MDU: stalls MDU ops until done, merges overflow into exc_o.
// Registers result/pc/exc into the E/M boundary whenever the M stage can accept.
module ex_stage_mdu
  import ex_stage_mdu_pkg::*;
#(
  parameter int W       = 32,
  parameter int MUL_LAT = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         valid_last,
  input  logic         allowin_next,
  output logic         allowin,
  output logic         ready_go,
  output logic         valid,
  input  logic [3:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] alu_i,
  input  logic         ov_i,
  input  logic [31:0]  pc_i,
  input  logic [4:0]   exc_i,
  output logic [W-1:0] result_o,
  output logic [31:0]  pc_o,
  output logic [4:0]   exc_o,
  output logic         start,
  output logic         busy
);

  logic         w_live, w_done;
  logic [W-1:0] w_hi, w_lo, w_res;
  logic [4:0]   w_exc;
  logic         r_valid;
  logic [W-1:0] r_result;
  logic [31:0]  r_pc;
  logic [4:0]   r_exc;

  assign w_live = valid_last && (exc_i == 5'd0) && !flush;

  ex_stage_mdu_iter #(.W(W), .MUL_LAT(MUL_LAT)) u_mdu_iter (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_flush        (flush),
    .i_live         (w_live),
    .i_allowin_next (allowin_next),
    .i_op           (op_i),
    .i_a            (a_i),
    .i_b            (b_i),
    .o_start        (start),
    .o_busy         (busy),
    .o_done         (w_done),
    .o_hi           (w_hi),
    .o_lo           (w_lo)
  );

  assign ready_go = w_done || !is_mdu_op(op_i) || !w_live;
  assign allowin  = ready_go && allowin_next;

  assign w_res = (op_i == MDU_MFHI) ? w_hi :
                 (op_i == MDU_MFLO) ? w_lo : alu_i;
  assign w_exc = (exc_i != 5'd0) ? exc_i : (ov_i ? EXC_OV : 5'd0);

  // A flush with M stalled still kills whatever sits in the E/M register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_pc     <= '0;
      r_exc    <= '0;
    end else if (allowin_next) begin
      r_valid  <= valid_last && ready_go && (exc_i == 5'd0) && !flush;
      r_result <= w_res;
      r_pc     <= pc_i;
      r_exc    <= w_exc;
    end else if (flush) begin
      r_valid  <= 1'b0;
    end
  end

  assign valid    = r_valid;
  assign result_o = r_result;
  assign pc_o     = r_pc;
  assign exc_o    = r_exc;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu: a driver queues expected E/M contents per accepted
// instruction, a monitor compares them after each accepting edge.
module tb_ex_stage_mdu;
  import ex_stage_mdu_pkg::*;

  localparam int W = 32;

  logic        clk, reset, flush, valid_last, allowin_next;
  logic        allowin, ready_go, valid, ov_i, start, busy;
  logic [3:0]  op_i;
  logic [31:0] a_i, b_i, alu_i, pc_i, result_o, pc_o;
  logic [4:0]  exc_i, exc_o;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        vld;
  } exp_t;

  exp_t        q_exp[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_n;

  ex_stage_mdu #(.W(W), .MUL_LAT(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_last(valid_last),
    .allowin_next(allowin_next), .allowin(allowin), .ready_go(ready_go), .valid(valid),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .alu_i(alu_i), .ov_i(ov_i), .pc_i(pc_i),
    .exc_i(exc_i), .result_o(result_o), .pc_o(pc_o), .exc_o(exc_o),
    .start(start), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  property p_hold_operands;
    @(posedge clk) disable iff (reset) !allowin |=> ($stable(op_i) && $stable(a_i) && $stable(b_i));
  endproperty
  a_hold_operands: assert property (p_hold_operands)
    else begin
      errors++;
      $display("FAIL operand_hold: op/a/b changed while allowin=0");
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every edge that accepts an instruction must produce the queued E/M contents.
  always begin
    @(negedge clk);
    if (!reset && valid_last && allowin) begin
      @(posedge clk);
      #1;
      checks++;
      if (q_exp.size() == 0) begin
        errors++;
        $display("FAIL em_unexpected: pc_o=%h with no expected entry", pc_o);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        if (result_o !== e.res || pc_o !== e.pc || exc_o !== e.exc || valid !== e.vld) begin
          errors++;
          $display("FAIL em_out: got res=%h pc=%h exc=%0d vld=%0b expected res=%h pc=%h exc=%0d vld=%0b",
                   result_o, pc_o, exc_o, valid, e.res, e.pc, e.exc, e.vld);
        end
      end
    end
  end

  // Drives one instruction from posedge+2 and holds it until accepted.
  // exp_rdy: cycle index (t0=0) where ready_go first rises; stall: extra cycles allowin_next stays low.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] alu, input logic ov, input logic [4:0] exc,
                       input logic [31:0] exp_res, input logic [4:0] exp_exc, input logic exp_vld,
                       input int exp_rdy, input int stall);
    int  k, first;
    bit  acc;
    op_i = op; a_i = a; b_i = b; alu_i = alu; ov_i = ov; exc_i = exc; pc_i = pc_n;
    valid_last   = 1'b1;
    allowin_next = (stall == 0);
    q_exp.push_back('{res: exp_res, pc: pc_n, exc: exp_exc, vld: exp_vld});
    pc_n  = pc_n + 32'd4;
    k     = 0;
    first = -1;
    acc   = 1'b0;
    while (!acc && k < 100) begin
      @(negedge clk);
      if (k == 0) chk("start_pulse", {31'd0, start}, {31'd0, exp_rdy > 0});
      if (ready_go && first < 0) first = k;
      if (allowin) acc = 1'b1;
      else begin
        @(posedge clk);
        #2;
        k++;
        if (k == exp_rdy + stall) allowin_next = 1'b1;
      end
    end
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: op=%0d not accepted within 100 cycles", op);
    end
    chk("ready_go_cycle", first, exp_rdy);
    chk("accept_cycle", k, exp_rdy + stall);
    @(posedge clk);
    #2;
    valid_last   = 1'b0;
    allowin_next = 1'b1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; valid_last = 1'b0; allowin_next = 1'b1;
    op_i = MDU_NONE; a_i = '0; b_i = '0; alu_i = '0; ov_i = 1'b0; pc_i = '0; exc_i = '0;
    pc_n = 32'h100;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_exc", {27'd0, exc_o}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // HI resets to zero
    issue(MDU_MFHI, 0, 0, 32'hDEAD, 0, 0, 32'h0, 0, 1, 0, 0);
    // MULT -3*7 = -21
    issue(MDU_MULT, 32'hFFFFFFFD, 32'd7, 32'h11, 0, 0, 32'h11, 0, 1, 6, 0);
    issue(MDU_MFLO, 0, 0, 32'hDEAD, 0, 0, 32'hFFFFFFEB, 0, 1, 0, 0);
    issue(MDU_MFHI, 0, 0, 32'hDEAD, 0, 0, 32'hFFFFFFFF, 0, 1, 0, 0);
    // DIVU 100/7
    issue(MDU_DIVU, 32'd100, 32'd7, 32'h22, 0, 0, 32'h22, 0, 1, 33, 0);
    issue(MDU_MFLO, 0, 0, 32'hDEAD, 0, 0, 32'd14, 0, 1, 0, 0);
    issue(MDU_MFHI, 0, 0, 32'hDEAD, 0, 0, 32'd2, 0, 1, 0, 0);
    // DIV -7/2 = -3 rem -1
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'h33, 0, 0, 32'h33, 0, 1, 33, 0);
    issue(MDU_MFLO, 0, 0, 32'hDEAD, 0, 0, 32'hFFFFFFFD, 0, 1, 0, 0);
    issue(MDU_MFHI, 0, 0, 32'hDEAD, 0, 0, 32'hFFFFFFFF, 0, 1, 0, 0);
    // DIV most-negative / -1
    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h44, 0, 0, 32'h44, 0, 1, 33, 0);
    issue(MDU_MFLO, 0, 0, 32'hDEAD, 0, 0, 32'h80000000, 0, 1, 0, 0);
    issue(MDU_MFHI, 0, 0, 32'hDEAD, 0, 0, 32'h0, 0, 1, 0, 0);
    // DIV 5/0: no exception
    issue(MDU_DIV, 32'd5, 32'd0, 32'h55, 0, 0, 32'h55, 0, 1, 33, 0);
    issue(MDU_MFLO, 0, 0, 32'hDEAD, 0, 0, 32'hFFFFFFFF, 0, 1, 0, 0);
    issue(MDU_MFHI, 0, 0, 32'hDEAD, 0, 0, 32'd5, 0, 1, 0, 0);
    // MULTU 0xFFFFFFFF*2 held in DONE for 4 cycles
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 32'h66, 0, 0, 32'h66, 0, 1, 6, 4);
    issue(MDU_MFHI, 0, 0, 32'hDEAD, 0, 0, 32'd1, 0, 1, 0, 0);
    issue(MDU_MFLO, 0, 0, 32'hDEAD, 0, 0, 32'hFFFFFFFE, 0, 1, 0, 0);

    // DIVU flushed at t3
    op_i = MDU_DIVU; a_i = 32'd50; b_i = 32'd5; alu_i = 32'h77; ov_i = 0; exc_i = 0;
    pc_i = pc_n; valid_last = 1'b1; allowin_next = 1'b1;
    q_exp.push_back('{res: 32'h77, pc: pc_n, exc: 5'd0, vld: 1'b0});
    pc_n = pc_n + 32'd4;
    repeat (3) @(posedge clk);
    #2;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_t3", {31'd0, busy}, 32'd1);
    chk("flush_allowin_t3", {31'd0, allowin}, 32'd1);
    @(posedge clk);
    #2;
    flush = 1'b0;
    valid_last = 1'b0;
    chk("flush_busy_t4", {31'd0, busy}, 32'd0);
    chk("flush_valid_t4", {31'd0, valid}, 32'd0);
    issue(MDU_MTHI, 32'h1234, 0, 32'h88, 0, 0, 32'h88, 0, 1, 0, 0);
    issue(MDU_MFHI, 0, 0, 32'hDEAD, 0, 0, 32'h1234, 0, 1, 0, 0);
    issue(MDU_MFLO, 0, 0, 32'hDEAD, 0, 0, 32'hFFFFFFFE, 0, 1, 0, 0);

    // MULT with pending exception: no start, no HI/LO write
    issue(MDU_MULT, 32'd9, 32'd9, 32'h99, 0, 5'd4, 32'h99, 5'd4, 0, 0, 0);
    issue(MDU_MFHI, 0, 0, 32'hDEAD, 0, 0, 32'h1234, 0, 1, 0, 0);
    issue(MDU_MFLO, 0, 0, 32'hDEAD, 0, 0, 32'hFFFFFFFE, 0, 1, 0, 0);
    // ALU overflow becomes exc 12
    issue(MDU_NONE, 0, 0, 32'hAB, 1, 0, 32'hAB, EXC_OV, 1, 0, 0);
    // MTLO then MFLO
    issue(MDU_MTLO, 32'h55, 0, 32'hBC, 0, 0, 32'hBC, 0, 1, 0, 0);
    issue(MDU_MFLO, 0, 0, 32'hDEAD, 0, 0, 32'h55, 0, 1, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", q_exp.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
